ddr_cmd_sequencer: RTL and testbench
====================================

# ddr_cmd_sequencer

Single-bank command sequencer that drives the testbench interface between the DDR controller, DIMM model and memory checker. It accepts one read/write transaction at a time and plays out ACT → tRCD → CAS → latency/burst → PRE → tRP. The handshake/strobe signals it produces (act_cmd, next_cmd, dev_rw, dev_rd, rw_proc, dev_busy) tell the DIMM model and checker where each transaction is. It also serialises burst-length changes (MR0 updates) between transactions and publishes the active BL.

## Interface
Parameters:
- T_RCD, 4: ACT-to-CAS delay in clocks (≥2)
- T_RP, 4: PRE-to-idle delay in clocks (≥1)
- T_CL, 5: read CAS latency in clocks (≥1)
- T_CWL, 4: write CAS latency in clocks (≥1)
- T_MRD, 8: MRS-to-next-command delay in clocks (≥1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  transaction request
- req_write  in  1  1 = write, 0 = read
- req_ready  out  1  sequencer can accept a request this cycle
- cfg_bl_req  in  1  request to change burst length
- cfg_bl  in  2  ddr_package bl_mode_t: 00 BL8, 01 on-the-fly, 10 BC4
- cfg_ack  out  1  one-cycle pulse when cfg_bl_req is taken
- act_cmd  out  1  one-cycle ACT strobe
- next_cmd  out  1  one-cycle CAS strobe
- dev_rw  out  2  00 none, 01 read, 10 write; valid from CAS to burst end
- dev_rd  out  1  high for each read-data beat cycle
- rw_proc  out  1  high from CAS through last data cycle
- dev_busy  out  1  high whenever state ≠ IDLE
- mrs_update  out  1  one-cycle MR0 write strobe
- bl_update  out  2  BL code written with mrs_update; holds last value
- BL  out  int  active burst length: 8 (BL8, on-the-fly) or 4 (BC4)

## Operation
- States: IDLE, MRS, MRD_WAIT, ACT, RCD_WAIT, CAS, LAT_WAIT, BURST, PRE, RP_WAIT.
- IDLE: req_ready = !cfg_bl_req. If cfg_bl_req is high, go to MRS and pulse cfg_ack; a request is not accepted that cycle. Otherwise, if req_valid, latch req_write and go to ACT.
- MRS: mrs_update = 1, bl_update ← cfg_bl (latched at ack). BL updates in the same cycle. Then MRD_WAIT for T_MRD-1 cycles, then IDLE.
- ACT: act_cmd = 1. Then RCD_WAIT for T_RCD-1 cycles.
- CAS: next_cmd = 1. dev_rw is set, rw_proc rises. Then LAT_WAIT for (read ? T_CL : T_CWL)-1 cycles.
- BURST: lasts BL/2 cycles (DDR). dev_rd = 1 each cycle for reads. dev_rw and rw_proc are held; both clear on exit.
- PRE: one cycle. Then RP_WAIT for T_RP-1 cycles, then IDLE.
- A single down-counter (width from the largest parameter) is loaded on state entry; the state exits when it reaches 0. A wait of 0 cycles skips the state.
- Requests presented outside IDLE are ignored; the requester holds req_valid until req_ready.
- A cfg_bl_req arriving mid-transaction is held off until IDLE and does not affect the in-flight burst length.
- Reset values: state IDLE, all strobes 0, dev_rw 00, bl_update 00, BL 8, req_ready 1.
- Reset asserted mid-transaction aborts it on the next edge; PRE is not issued.

## Timing
- Request accepted at edge N gives: act_cmd at N+1, next_cmd at N+1+T_RCD, first burst cycle at N+1+T_RCD+latency.
- Read with defaults (BL8): act at N+1, CAS at N+5, dev_rd high N+10..N+13, PRE at N+14, IDLE at N+18. req_ready returns at N+18.
- Back-to-back transactions are separated by ≥T_RP cycles after PRE; there is no bypass.
- Simultaneous cfg_bl_req and req_valid in IDLE: cfg_bl_req wins.

## Structure
- ddr_package holds:
  - bl_mode_t
  - dev_rw encodings: RW_NONE, RW_RD, RW_WR
  - the state enum seq_state_t
  - default timing constants
- One sub-module, ddr_wait_counter: a loadable down-counter with a done flag, reused by every wait state.
- Top level connects its outputs to TB_INTERFACE signals of the same names.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values; BL = 8; dev_busy 0.
- Single read, defaults → act at N+1, next_cmd at N+5, dev_rw = 01 N+5..N+13, 4 dev_rd cycles, req_ready at N+18.
- Single write → dev_rd never high; BURST starts at N+9; dev_rw = 10.
- cfg_bl = 10 in IDLE, then a read → mrs_update pulse, bl_update = 10, BL = 4, IDLE after 8 cycles; read burst lasts 2 cycles.
- cfg_bl_req raised during a read burst → burst keeps 4 cycles; MRS occurs the cycle after returning to IDLE.
- reset_n low at the CAS cycle → next edge: IDLE, rw_proc 0, no PRE; the following request completes normally.

Source files
------------

// File: rtl/ddr_cmd_sequencer_pkg.sv
// Shared types and default timing for the single-bank DDR command sequencer.
package ddr_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        BL_8   = 2'b00,
        BL_OTF = 2'b01,
        BL_BC4 = 2'b10
    } bl_mode_t;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_RD   = 2'b01;
    localparam logic [1:0] RW_WR   = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        MRS,
        MRD_WAIT,
        ACT,
        RCD_WAIT,
        CAS,
        LAT_WAIT,
        BURST,
        PRE,
        RP_WAIT
    } seq_state_t;

    localparam int DEF_T_RCD = 4;
    localparam int DEF_T_RP  = 4;
    localparam int DEF_T_CL  = 5;
    localparam int DEF_T_CWL = 4;
    localparam int DEF_T_MRD = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_wait_counter.sv
// Loadable down-counter shared by all sequencer wait states; done flags zero.
module ddr_wait_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Single-bank DDR command sequencer: ACT/CAS/burst/PRE playout plus serialised
// MR0 burst-length updates between transactions.
//
// state    | meaning
// IDLE     | ready for a request or a burst-length change
// MRS      | MR0 write strobe, new BL takes effect
// MRD_WAIT | MRS-to-next-command recovery
// ACT      | row activate strobe
// RCD_WAIT | ACT-to-CAS delay
// CAS      | column command strobe, transfer window opens
// LAT_WAIT | read/write CAS latency
// BURST    | data beats, BL/2 clocks
// PRE      | precharge
// RP_WAIT  | precharge recovery
module ddr_cmd_sequencer
    import ddr_cmd_sequencer_pkg::*;
#(
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_CL  = DEF_T_CL,
    parameter int T_CWL = DEF_T_CWL,
    parameter int T_MRD = DEF_T_MRD
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic       req_write,
    output logic       req_ready,
    input  logic       cfg_bl_req,
    input  logic [1:0] cfg_bl,
    output logic       cfg_ack,
    output logic       act_cmd,
    output logic       next_cmd,
    output logic [1:0] dev_rw,
    output logic       dev_rd,
    output logic       rw_proc,
    output logic       dev_busy,
    output logic       mrs_update,
    output logic [1:0] bl_update,
    output int         BL
);

    localparam int MAX_T = max_int(max_int(max_int(T_RCD, T_RP), max_int(T_CL, T_CWL)),
                                   max_int(T_MRD, 4));
    localparam int CW    = $clog2(MAX_T + 1);

    seq_state_t    state, state_next;
    logic          wr_q;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_done;
    logic [CW-1:0] lat_m2;
    logic          lat_skip;
    logic [CW-1:0] burst_m1;
    logic [1:0]    rw_code;

    ddr_wait_counter #(.W(CW)) u_wait (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // The counter holds (cycles - 1), so a wait of N cycles loads N-2 one state early.
    assign lat_m2   = wr_q ? CW'(T_CWL - 2) : CW'(T_CL - 2);
    assign lat_skip = wr_q ? (T_CWL == 1) : (T_CL == 1);
    assign burst_m1 = CW'(BL / 2 - 1);
    assign rw_code  = wr_q ? RW_WR : RW_RD;
    assign dev_busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            bl_update <= BL_8;
            BL        <= 8;
        end else begin
            state <= state_next;
            if (state == IDLE && !cfg_bl_req && req_valid) begin
                wr_q <= req_write;
            end
            if (cfg_ack) begin
                bl_update <= cfg_bl;
                BL        <= (cfg_bl == BL_BC4) ? 4 : 8;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        req_ready  = 1'b0;
        cfg_ack    = 1'b0;
        act_cmd    = 1'b0;
        next_cmd   = 1'b0;
        dev_rw     = RW_NONE;
        dev_rd     = 1'b0;
        rw_proc    = 1'b0;
        mrs_update = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !cfg_bl_req;
                if (cfg_bl_req) begin
                    cfg_ack    = 1'b1;
                    state_next = MRS;
                end else if (req_valid) begin
                    state_next = ACT;
                end
            end
            MRS: begin
                mrs_update = 1'b1;
                if (T_MRD > 1) begin
                    state_next = MRD_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = CW'(T_MRD - 2);
                end else begin
                    state_next = IDLE;
                end
            end
            MRD_WAIT: begin
                if (cnt_done) state_next = IDLE;
            end
            ACT: begin
                act_cmd = 1'b1;
                if (T_RCD > 1) begin
                    state_next = RCD_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = CW'(T_RCD - 2);
                end else begin
                    state_next = CAS;
                end
            end
            RCD_WAIT: begin
                if (cnt_done) state_next = CAS;
            end
            CAS: begin
                next_cmd = 1'b1;
                dev_rw   = rw_code;
                rw_proc  = 1'b1;
                cnt_load = 1'b1;
                if (lat_skip) begin
                    state_next = BURST;
                    cnt_val    = burst_m1;
                end else begin
                    state_next = LAT_WAIT;
                    cnt_val    = lat_m2;
                end
            end
            LAT_WAIT: begin
                dev_rw  = rw_code;
                rw_proc = 1'b1;
                if (cnt_done) begin
                    state_next = BURST;
                    cnt_load   = 1'b1;
                    cnt_val    = burst_m1;
                end
            end
            BURST: begin
                dev_rw  = rw_code;
                rw_proc = 1'b1;
                dev_rd  = !wr_q;
                if (cnt_done) state_next = PRE;
            end
            PRE: begin
                if (T_RP > 1) begin
                    state_next = RP_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = CW'(T_RP - 2);
                end else begin
                    state_next = IDLE;
                end
            end
            RP_WAIT: begin
                if (cnt_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Scoreboard bench for ddr_cmd_sequencer: expected output-change events are
// queued when stimulus is applied and matched as the outputs change.
module tb_ddr_cmd_sequencer;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_CL  = 5;
    localparam int T_CWL = 4;
    localparam int T_MRD = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic       req_ready;
    logic       cfg_bl_req = 1'b0;
    logic [1:0] cfg_bl = 2'b00;
    logic       cfg_ack;
    logic       act_cmd;
    logic       next_cmd;
    logic [1:0] dev_rw;
    logic       dev_rd;
    logic       rw_proc;
    logic       dev_busy;
    logic       mrs_update;
    logic [1:0] bl_update;
    int         BL;

    ddr_cmd_sequencer #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_CWL(T_CWL), .T_MRD(T_MRD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_ready  (req_ready),
        .cfg_bl_req (cfg_bl_req),
        .cfg_bl     (cfg_bl),
        .cfg_ack    (cfg_ack),
        .act_cmd    (act_cmd),
        .next_cmd   (next_cmd),
        .dev_rw     (dev_rw),
        .dev_rd     (dev_rd),
        .rw_proc    (rw_proc),
        .dev_busy   (dev_busy),
        .mrs_update (mrs_update),
        .bl_update  (bl_update),
        .BL         (BL)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [9:0] sig;
    } ev_t;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev_sig = '0;
    logic [9:0] cur_sig;
    ev_t        cur_ev;
    logic [1:0] m_blu = 2'b00;
    logic       m_bc4 = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [9:0] mk(input logic act, input logic nxt, input logic rd,
                                      input logic mrs, input logic [1:0] rw, input logic proc,
                                      input logic busy, input logic [1:0] blu);
        return {act, nxt, rd, mrs, rw, proc, busy, blu};
    endfunction

    task automatic push_ev(input int c, input logic [9:0] s);
        ev_t e;
        e.cyc = c;
        e.sig = s;
        sb.push_back(e);
    endtask

    // Each label is the edge index at which a spec-style observer sees the value.
    always @(negedge clock) begin
        if (mon_en) begin
            cur_sig = {act_cmd, next_cmd, dev_rd, mrs_update, dev_rw, rw_proc, dev_busy, bl_update};
            if (cur_sig !== prev_sig) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(cur_sig), 32'(prev_sig));
                end else begin
                    cur_ev = sb.pop_front();
                    chk("event_cycle", cyc + 1, cur_ev.cyc);
                    chk("event_value", 32'(cur_sig), 32'(cur_ev.sig));
                end
                prev_sig = cur_sig;
            end
        end
    end

    task automatic push_txn(input int n, input logic wr, output int b, output int idle);
        int lat, bb, c, e;
        logic [1:0] rw;
        lat  = wr ? T_CWL : T_CL;
        bb   = m_bc4 ? 2 : 4;
        rw   = wr ? 2'b10 : 2'b01;
        c    = n + 1 + T_RCD;
        b    = c + lat;
        e    = b + bb;
        idle = e + T_RP;
        push_ev(n + 1, mk(1, 0, 0, 0, 2'b00, 0, 1, m_blu));
        push_ev(n + 2, mk(0, 0, 0, 0, 2'b00, 0, 1, m_blu));
        push_ev(c,     mk(0, 1, 0, 0, rw, 1, 1, m_blu));
        push_ev(c + 1, mk(0, 0, 0, 0, rw, 1, 1, m_blu));
        if (!wr) push_ev(b, mk(0, 0, 1, 0, rw, 1, 1, m_blu));
        push_ev(e,     mk(0, 0, 0, 0, 2'b00, 0, 1, m_blu));
        push_ev(idle,  mk(0, 0, 0, 0, 2'b00, 0, 0, m_blu));
    endtask

    task automatic push_mrs(input int n, input logic [1:0] code);
        m_blu = code;
        m_bc4 = (code == 2'b10);
        push_ev(n + 1,     mk(0, 0, 0, 1, 2'b00, 0, 1, code));
        push_ev(n + 2,     mk(0, 0, 0, 0, 2'b00, 0, 1, code));
        push_ev(n + 1 + T_MRD, mk(0, 0, 0, 0, 2'b00, 0, 0, code));
    endtask

    task automatic issue_req(input logic wr, output int n);
        int k;
        req_valid = 1'b1;
        req_write = wr;
        k = 0;
        @(negedge clock);
        while (!req_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (k >= 100) chk("req_ready_timeout", k, 0);
        @(posedge clock);
        #1;
        n = cyc;
        req_valid = 1'b0;
    endtask

    task automatic cfg_in_idle(input logic [1:0] code, input logic also_req, input logic wr);
        int n;
        cfg_bl_req = 1'b1;
        cfg_bl     = code;
        if (also_req) begin
            req_valid = 1'b1;
            req_write = wr;
        end
        @(negedge clock);
        chk("cfg_ack_idle", cfg_ack, 1);
        chk("req_ready_blocked", req_ready, 0);
        @(posedge clock);
        #1;
        n = cyc;
        cfg_bl_req = 1'b0;
        push_mrs(n, code);
        @(negedge clock);
        chk("bl_after_mrs", BL, m_bc4 ? 4 : 8);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || dev_busy) && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (k >= 300) chk("idle_timeout", k, 0);
        chk("req_ready_idle", req_ready, 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int n, b, idle, c;

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("rst_act", act_cmd, 0);
        chk("rst_next", next_cmd, 0);
        chk("rst_dev_rw", dev_rw, 0);
        chk("rst_dev_rd", dev_rd, 0);
        chk("rst_rw_proc", rw_proc, 0);
        chk("rst_busy", dev_busy, 0);
        chk("rst_mrs", mrs_update, 0);
        chk("rst_bl_update", bl_update, 0);
        chk("rst_bl", BL, 8);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cfg_ack", cfg_ack, 0);

        // BL8 read, then BL8 write
        issue_req(1'b0, n);
        push_txn(n, 1'b0, b, idle);
        wait_idle();
        issue_req(1'b1, n);
        push_txn(n, 1'b1, b, idle);
        wait_idle();

        // BC4 selected in IDLE, then a two-beat-cycle read
        cfg_in_idle(2'b10, 1'b0, 1'b0);
        wait_idle();
        issue_req(1'b0, n);
        push_txn(n, 1'b0, b, idle);
        wait_idle();

        cfg_in_idle(2'b00, 1'b0, 1'b0);
        wait_idle();

        // burst-length change raised mid-burst is deferred until IDLE
        issue_req(1'b0, n);
        push_txn(n, 1'b0, b, idle);
        wait_cyc(b);
        cfg_bl_req = 1'b1;
        cfg_bl     = 2'b10;
        @(negedge clock);
        chk("cfg_ack_held_off", cfg_ack, 0);
        chk("bl_in_flight", BL, 8);
        @(posedge clock);
        #1;
        wait_cyc(idle - 1);
        @(negedge clock);
        chk("cfg_ack_at_idle", cfg_ack, 1);
        chk("req_ready_at_idle", req_ready, 0);
        @(posedge clock);
        #1;
        cfg_bl_req = 1'b0;
        push_mrs(cyc, 2'b10);
        @(negedge clock);
        chk("bl_deferred_mrs", BL, 4);
        @(posedge clock);
        #1;
        wait_idle();

        // simultaneous cfg and request: cfg wins, write follows
        cfg_in_idle(2'b01, 1'b1, 1'b1);
        issue_req(1'b1, n);
        push_txn(n, 1'b1, b, idle);
        wait_idle();

        // reset during CAS aborts without PRE
        issue_req(1'b0, n);
        c = n + 1 + T_RCD;
        push_ev(n + 1, mk(1, 0, 0, 0, 2'b00, 0, 1, m_blu));
        push_ev(n + 2, mk(0, 0, 0, 0, 2'b00, 0, 1, m_blu));
        push_ev(c,     mk(0, 1, 0, 0, 2'b01, 1, 1, m_blu));
        m_blu = 2'b00;
        m_bc4 = 1'b0;
        push_ev(c + 1, mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        wait_cyc(c - 1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("abort_rw_proc", rw_proc, 0);
        chk("abort_busy", dev_busy, 0);
        chk("abort_bl", BL, 8);
        issue_req(1'b0, n);
        push_txn(n, 1'b0, b, idle);
        wait_idle();

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
